// File: rtl/prot_pkg.sv
// Shared state encoding and default timing for the power-path protection sequencer.
package prot_pkg;

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_PRECHARGE = 3'd1,
    ST_ON        = 3'd2,
    ST_DERATE    = 3'd3,
    ST_RAMPDOWN  = 3'd4,
    ST_LOCKOUT   = 3'd5
  } prot_state_e;

  localparam int DEF_PRECHARGE_CYC = 16;
  localparam int DEF_OFF_DELAY     = 4;
  localparam int DEF_RETRY_WAIT    = 64;
  localparam int DEF_MAX_RETRY     = 3;
  localparam int TMR_W             = 16;

  // A timer loaded with N-1 reports done on the Nth cycle of the interval.
  function automatic logic [TMR_W-1:0] tmr_load(input int cycles);
    return TMR_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/prot_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module prot_timer
  import prot_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/prot_sequencer.sv
// Power-path start-up / shut-down sequencer with fault lockout.
// Define PROT_SEQ_RETRY_EN to enable automatic retry out of lockout.
module prot_sequencer
  import prot_pkg::*;
#(
  parameter int PRECHARGE_CYC = DEF_PRECHARGE_CYC,
  parameter int OFF_DELAY     = DEF_OFF_DELAY,
  parameter int RETRY_WAIT    = DEF_RETRY_WAIT,
  parameter int MAX_RETRY     = DEF_MAX_RETRY
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       warning,
  input  logic       fault,
  input  logic       shutdown,
  input  logic       start,
  input  logic       clear,
  output logic       precharge_en,
  output logic       gate_en,
  output logic       load_en,
  output logic       derate,
  output logic       alarm,
  output logic [2:0] state_o,
  output logic [7:0] trip_cnt
);

  if (PRECHARGE_CYC < 1 || OFF_DELAY < 1 || RETRY_WAIT < 1 ||
      PRECHARGE_CYC > 2**TMR_W || OFF_DELAY > 2**TMR_W || RETRY_WAIT > 2**TMR_W ||
      MAX_RETRY < 0 || MAX_RETRY > 255) begin : g_bad_cfg
    $error("prot_sequencer: unsupported timing parameters");
  end

  prot_state_e state, state_nxt;
  logic        trip;
  logic        trip_latch, latch_nxt;
  logic        ramp_entry;
  logic        pre_load, pre_done;
  logic        off_done;
  logic        gate_nxt;

  assign trip    = fault | shutdown;
  assign state_o = state;

`ifdef PROT_SEQ_RETRY_EN
  logic       retry_load, retry_done, retry_ok;
  logic [7:0] retry_cnt;

  // Any trip cycle in lockout reloads the wait so only an unbroken clean run counts.
  assign retry_load = (state_nxt == ST_LOCKOUT) && ((state != ST_LOCKOUT) || trip);
  assign retry_ok   = retry_done && (retry_cnt < 8'(MAX_RETRY));

  prot_timer u_retry_tmr (
    .clk      (clk),
    .rstn     (rstn),
    .load     (retry_load),
    .load_val (tmr_load(RETRY_WAIT)),
    .en       (state == ST_LOCKOUT),
    .done     (retry_done)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      retry_cnt <= 8'd0;
    end else if ((state == ST_LOCKOUT) && (state_nxt == ST_OFF)) begin
      retry_cnt <= (clear && !trip) ? 8'd0 : retry_cnt + 8'd1;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    latch_nxt = trip_latch;
    pre_load  = 1'b0;
    case (state)
      ST_OFF: begin
        if (start && !trip) begin
          state_nxt = ST_PRECHARGE;
          pre_load  = 1'b1;
        end
      end
      ST_PRECHARGE: begin
        if (trip) begin
          state_nxt = ST_RAMPDOWN;
          latch_nxt = 1'b1;
        end else if (!start) begin
          state_nxt = ST_OFF;
        end else if (pre_done) begin
          state_nxt = ST_ON;
        end
      end
      ST_ON, ST_DERATE: begin
        if (trip) begin
          state_nxt = ST_RAMPDOWN;
          latch_nxt = 1'b1;
        end else if (!start) begin
          state_nxt = ST_RAMPDOWN;
        end else if (warning) begin
          state_nxt = ST_DERATE;
        end else begin
          state_nxt = ST_ON;
        end
      end
      ST_RAMPDOWN: begin
        if (trip) latch_nxt = 1'b1;
        // Leave only once the gate has actually been seen low for a cycle.
        if (off_done && !gate_en) begin
          state_nxt = (trip_latch || trip) ? ST_LOCKOUT : ST_OFF;
        end
      end
      ST_LOCKOUT: begin
        if (clear && !trip) begin
          state_nxt = ST_OFF;
        end
`ifdef PROT_SEQ_RETRY_EN
        else if (!trip && retry_ok) begin
          state_nxt = ST_OFF;
        end
`endif
      end
      default: begin
        state_nxt = ST_RAMPDOWN;
        latch_nxt = 1'b1;
      end
    endcase

    ramp_entry = (state_nxt == ST_RAMPDOWN) && (state != ST_RAMPDOWN);
    if (state_nxt != ST_RAMPDOWN) latch_nxt = 1'b0;

    case (state_nxt)
      ST_ON, ST_DERATE: gate_nxt = 1'b1;
      ST_RAMPDOWN:      gate_nxt = ramp_entry ? gate_en : (gate_en && !off_done);
      default:          gate_nxt = 1'b0;
    endcase
  end

  prot_timer u_pre_tmr (
    .clk      (clk),
    .rstn     (rstn),
    .load     (pre_load),
    .load_val (tmr_load(PRECHARGE_CYC)),
    .en       (state == ST_PRECHARGE),
    .done     (pre_done)
  );

  prot_timer u_off_tmr (
    .clk      (clk),
    .rstn     (rstn),
    .load     (ramp_entry),
    .load_val (tmr_load(OFF_DELAY)),
    .en       (state == ST_RAMPDOWN),
    .done     (off_done)
  );

  // Outputs are decoded from the next state so every drive is a flop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= ST_OFF;
      trip_latch   <= 1'b0;
      precharge_en <= 1'b0;
      gate_en      <= 1'b0;
      load_en      <= 1'b0;
      derate       <= 1'b0;
      alarm        <= 1'b0;
      trip_cnt     <= 8'd0;
    end else begin
      state        <= state_nxt;
      trip_latch   <= latch_nxt;
      precharge_en <= (state_nxt == ST_PRECHARGE);
      gate_en      <= gate_nxt;
      load_en      <= (state_nxt == ST_ON) || (state_nxt == ST_DERATE);
      derate       <= (state_nxt == ST_DERATE);
      alarm        <= (state_nxt == ST_LOCKOUT);
      if (ramp_entry && latch_nxt && (trip_cnt != 8'hFF)) begin
        trip_cnt <= trip_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_prot_sequencer.sv
// Directed self-checking bench for prot_sequencer (retry scenario only when PROT_SEQ_RETRY_EN is defined).
module tb_prot_sequencer;

  logic       clk = 1'b0;
  logic       rstn, warning, fault, shutdown, start, clear;
  logic       precharge_en, gate_en, load_en, derate, alarm;
  logic [2:0] state_o;
  logic [7:0] trip_cnt;
  int         checks = 0;
  int         errors = 0;

  // Packed view {precharge_en, gate_en, load_en, derate, alarm, state_o}.
  wire [7:0] outs = {precharge_en, gate_en, load_en, derate, alarm, state_o};

  localparam logic [7:0] O_OFF  = 8'b0000_0000;
  localparam logic [7:0] O_PRE  = 8'b1000_0001;
  localparam logic [7:0] O_ON   = 8'b0110_0010;
  localparam logic [7:0] O_DER  = 8'b0111_0011;
  localparam logic [7:0] O_RDG  = 8'b0100_0100;
  localparam logic [7:0] O_RD   = 8'b0000_0100;
  localparam logic [7:0] O_LOCK = 8'b0000_1101;

  prot_sequencer dut (
    .clk          (clk),
    .rstn         (rstn),
    .warning      (warning),
    .fault        (fault),
    .shutdown     (shutdown),
    .start        (start),
    .clear        (clear),
    .precharge_en (precharge_en),
    .gate_en      (gate_en),
    .load_en      (load_en),
    .derate       (derate),
    .alarm        (alarm),
    .state_o      (state_o),
    .trip_cnt     (trip_cnt)
  );

  always #5 clk = ~clk;

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rstn = 1'b0; warning = 1'b0; fault = 1'b0; shutdown = 1'b0; start = 1'b0; clear = 1'b0;
    #2;
    checks++;
    if (outs !== O_OFF) begin
      errors++; $display("[TB] FAIL reset_outs: got %b expected %b", outs, O_OFF);
    end
    checks++;
    if (trip_cnt !== 8'd0) begin
      errors++; $display("[TB] FAIL reset_trip_cnt: got %0d expected 0", trip_cnt);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_precharge;
    start = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if (outs !== O_PRE) begin
        errors++; $display("[TB] FAIL precharge_cycle%0d: got %b expected %b", i, outs, O_PRE);
      end
    end
    @(negedge clk);
    checks++;
    if (outs !== O_ON) begin
      errors++; $display("[TB] FAIL precharge_to_on: got %b expected %b", outs, O_ON);
    end
  endtask

  task automatic test_warning;
    warning = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (outs !== O_DER) begin
        errors++; $display("[TB] FAIL derate_cycle%0d: got %b expected %b", i, outs, O_DER);
      end
      if (i == 4) warning = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (outs !== O_ON) begin
      errors++; $display("[TB] FAIL derate_to_on: got %b expected %b", outs, O_ON);
    end
  endtask

  task automatic test_fault_lockout;
    fault = 1'b1;
    @(negedge clk);
    fault = 1'b0;
    checks++;
    if (outs !== O_RDG) begin
      errors++; $display("[TB] FAIL fault_load_drop: got %b expected %b", outs, O_RDG);
    end
    checks++;
    if (trip_cnt !== 8'd1) begin
      errors++; $display("[TB] FAIL fault_trip_cnt: got %0d expected 1", trip_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (outs !== O_RDG) begin
        errors++; $display("[TB] FAIL fault_gate_hold%0d: got %b expected %b", i, outs, O_RDG);
      end
    end
    @(negedge clk);
    checks++;
    if (outs !== O_RD) begin
      errors++; $display("[TB] FAIL fault_gate_drop: got %b expected %b", outs, O_RD);
    end
    @(negedge clk);
    checks++;
    if (outs !== O_LOCK) begin
      errors++; $display("[TB] FAIL fault_lockout: got %b expected %b", outs, O_LOCK);
    end
    checks++;
    if (trip_cnt !== 8'd1) begin
      errors++; $display("[TB] FAIL lockout_trip_cnt: got %0d expected 1", trip_cnt);
    end
  endtask

  task automatic test_clear;
    shutdown = 1'b1; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0; shutdown = 1'b0;
    checks++;
    if (outs !== O_LOCK) begin
      errors++; $display("[TB] FAIL clear_during_trip: got %b expected %b", outs, O_LOCK);
    end
    @(negedge clk);
    checks++;
    if (outs !== O_LOCK) begin
      errors++; $display("[TB] FAIL lockout_hold: got %b expected %b", outs, O_LOCK);
    end
    start = 1'b0; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++;
    if (outs !== O_OFF) begin
      errors++; $display("[TB] FAIL clear_to_off: got %b expected %b", outs, O_OFF);
    end
  endtask

  task automatic test_priority;
    start = 1'b1;
    wait_cycles(17);
    checks++;
    if (outs !== O_ON) begin
      errors++; $display("[TB] FAIL prio_reach_on: got %b expected %b", outs, O_ON);
    end
    warning = 1'b1; fault = 1'b1;
    @(negedge clk);
    warning = 1'b0; fault = 1'b0;
    checks++;
    if (outs !== O_RDG) begin
      errors++; $display("[TB] FAIL prio_trip_wins: got %b expected %b", outs, O_RDG);
    end
    checks++;
    if (trip_cnt !== 8'd2) begin
      errors++; $display("[TB] FAIL prio_trip_cnt: got %0d expected 2", trip_cnt);
    end
    wait_cycles(5);
    checks++;
    if (outs !== O_LOCK) begin
      errors++; $display("[TB] FAIL prio_lockout: got %b expected %b", outs, O_LOCK);
    end
    start = 1'b0; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++;
    if (outs !== O_OFF) begin
      errors++; $display("[TB] FAIL prio_clear: got %b expected %b", outs, O_OFF);
    end
  endtask

  task automatic test_stop_rampdown;
    start = 1'b1;
    wait_cycles(17);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== O_RDG) begin
      errors++; $display("[TB] FAIL stop_rampdown: got %b expected %b", outs, O_RDG);
    end
    checks++;
    if (trip_cnt !== 8'd2) begin
      errors++; $display("[TB] FAIL stop_trip_cnt: got %0d expected 2", trip_cnt);
    end
    wait_cycles(4);
    checks++;
    if (outs !== O_RD) begin
      errors++; $display("[TB] FAIL stop_gate_drop: got %b expected %b", outs, O_RD);
    end
    @(negedge clk);
    checks++;
    if (outs !== O_OFF) begin
      errors++; $display("[TB] FAIL stop_to_off: got %b expected %b", outs, O_OFF);
    end
  endtask

  task automatic test_late_trip;
    start = 1'b1;
    wait_cycles(17);
    start = 1'b0;
    wait_cycles(2);
    fault = 1'b1;
    @(negedge clk);
    fault = 1'b0;
    checks++;
    if (outs !== O_RDG) begin
      errors++; $display("[TB] FAIL late_trip_gate_held: got %b expected %b", outs, O_RDG);
    end
    wait_cycles(2);
    checks++;
    if (outs !== O_RD) begin
      errors++; $display("[TB] FAIL late_trip_no_restart: got %b expected %b", outs, O_RD);
    end
    @(negedge clk);
    checks++;
    if (outs !== O_LOCK) begin
      errors++; $display("[TB] FAIL late_trip_lockout: got %b expected %b", outs, O_LOCK);
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset_mid_precharge;
    start = 1'b1;
    wait_cycles(8);
    checks++;
    if (outs !== O_PRE) begin
      errors++; $display("[TB] FAIL midpre_state: got %b expected %b", outs, O_PRE);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (outs !== O_OFF) begin
      errors++; $display("[TB] FAIL async_reset_outs: got %b expected %b", outs, O_OFF);
    end
    checks++;
    if (trip_cnt !== 8'd0) begin
      errors++; $display("[TB] FAIL async_reset_trip_cnt: got %0d expected 0", trip_cnt);
    end
    start = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== O_OFF) begin
      errors++; $display("[TB] FAIL post_reset_idle: got %b expected %b", outs, O_OFF);
    end
  endtask

`ifdef PROT_SEQ_RETRY_EN
  task automatic test_retry;
    int n;
    bit seen;
    start = 1'b1;
    for (int r = 1; r <= 4; r++) begin
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge clk);
        if (state_o == 3'd2) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
        errors++; $display("[TB] FAIL retry%0d_reach_on: got state %0d expected 2", r, state_o);
      end
      fault = 1'b1;
      @(negedge clk);
      fault = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (state_o == 3'd5) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
        errors++; $display("[TB] FAIL retry%0d_lockout: got state %0d expected 5", r, state_o);
      end
      if (r < 4) begin
        n = 0;
        seen = 1'b0;
        while (n < 200 && !seen) begin
          @(negedge clk);
          n++;
          if (state_o == 3'd0) seen = 1'b1;
        end
        checks++;
        if (n !== 64) begin
          errors++; $display("[TB] FAIL retry%0d_wait: got %0d cycles expected 64", r, n);
        end
      end else begin
        wait_cycles(100);
        checks++;
        if (outs !== O_LOCK) begin
          errors++; $display("[TB] FAIL retry_exhausted: got %b expected %b", outs, O_LOCK);
        end
      end
    end
    checks++;
    if (trip_cnt !== 8'd4) begin
      errors++; $display("[TB] FAIL retry_trip_cnt: got %0d expected 4", trip_cnt);
    end
    start = 1'b0; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_precharge();
    test_warning();
    test_fault_lockout();
    test_clear();
    test_priority();
    test_stop_rampdown();
    test_late_trip();
    test_reset_mid_precharge();
`ifdef PROT_SEQ_RETRY_EN
    test_retry();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
